// File: rtl/rom_loader_pkg.sv
// Shared constants and types for the ROM download-to-SDRAM loader.
// Optional checksum logic in the top level is enabled by ROM_LOADER_CHECKSUM_EN.
package rom_loader_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int TAIL_LEN   = 16;

  localparam logic [8:0] PAGE_BASE_0 = 9'h000;
  localparam logic [8:0] PAGE_BASE_1 = 9'h100;
  localparam logic [8:0] PAGE_BASE_2 = 9'h107;
  localparam logic [8:0] PAGE_BASE_3 = 9'h1FF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  bank;
    logic [7:0]  data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Pages 0-3 and 4-7 share the same upper-address table; bank selects the half.
  function automatic logic [8:0] page_base(input logic [1:0] sel);
    logic [8:0] base;
    case (sel)
      2'd0:    base = PAGE_BASE_0;
      2'd1:    base = PAGE_BASE_1;
      2'd2:    base = PAGE_BASE_2;
      default: base = PAGE_BASE_3;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/rom_loader_fifo.sv
// Small synchronous FIFO with full/empty flags and same-cycle push/pop when full.
module rom_loader_fifo #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (do_pop)  rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Maps download bytes onto SDRAM pages, queues them and issues held write requests.
// Defining ROM_LOADER_CHECKSUM_EN adds the csum/csum_valid outputs.
module rom_loader
  import rom_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_din,
  output logic        hold_reset,
  output logic        overflow,
  output logic [7:0]  dropped
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] csum,
  output logic        csum_valid
`endif
);

  localparam int TAIL_W = $clog2(TAIL_LEN);

  state_e             state_q;
  logic               mem_we_q;
  logic [22:0]        mem_addr_q;
  logic [1:0]         mem_bank_q;
  logic [7:0]         mem_din_q;
  logic               act_q, hold_q, ovf_q;
  logic [7:0]         drop_q, drop_d;
  logic [TAIL_W-1:0]  tail_q;
  logic               vld_p0_q;
  entry_t             ent_p0_q, ent_map, fifo_head;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;
  logic               pop, rise, accept, in_range, idle, tail_done;
  logic [10:0]        page;

  assign page      = dl_addr[24:14];
  assign in_range  = (page[10:3] == 8'd0);
  assign accept    = dl_active & dl_wr;
  assign rise      = dl_active & ~act_q;
  assign pop       = (state_q == ST_REQ) & mem_ack;
  assign idle      = ~dl_active & fifo_empty & ~vld_p0_q & (state_q == ST_IDLE);
  assign tail_done = hold_q & idle & ~rise & (tail_q == TAIL_W'(TAIL_LEN - 1));
  assign fifo_head = entry_t'(fifo_rdata);

  always_comb begin
    ent_map.addr = {page_base(page[1:0]), dl_addr[13:0]};
    ent_map.bank = {1'b0, page[2]};
    ent_map.data = dl_data;
  end

  always_comb begin
    drop_d = rise ? 8'd0 : drop_q;
    if (accept && !in_range && drop_d != 8'hFF) drop_d = drop_d + 8'd1;
  end

  // Stage p0: mapped byte registered, pushed into the FIFO on the following edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) vld_p0_q <= 1'b0;
    else          vld_p0_q <= accept & in_range;
  end

  always_ff @(posedge clk_sys) begin
    if (accept) ent_p0_q <= ent_map;
  end

  rom_loader_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (vld_p0_q),
    .pop     (pop),
    .wdata   (ent_p0_q),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stage p1: write request; address/data latched once and held until acknowledged
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_bank_q <= '0;
      mem_din_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ST_REQ;
            mem_we_q   <= 1'b1;
            mem_addr_q <= fifo_head.addr;
            mem_bank_q <= fifo_head.bank;
            mem_din_q  <= fifo_head.data;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_q  <= ST_IDLE;
            mem_we_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      act_q  <= 1'b0;
      hold_q <= 1'b0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      act_q  <= dl_active;
      drop_q <= drop_d;
      if (vld_p0_q && fifo_full && !pop) ovf_q <= 1'b1;
      // Tail only advances while fully drained; any activity restarts it
      if (rise) begin
        hold_q <= 1'b1;
        tail_q <= '0;
      end else if (hold_q && idle) begin
        if (tail_done) begin
          hold_q <= 1'b0;
          tail_q <= '0;
        end else begin
          tail_q <= tail_q + TAIL_W'(1);
        end
      end else begin
        tail_q <= '0;
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;
  logic        csum_valid_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_q <= (rise ? 16'd0 : csum_q) + (pop ? {8'd0, fifo_head.data} : 16'd0);
      if (rise)           csum_valid_q <= 1'b0;
      else if (tail_done) csum_valid_q <= 1'b1;
    end
  end

  assign csum       = csum_q;
  assign csum_valid = csum_valid_q;
`endif

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_bank   = mem_bank_q;
  assign mem_din    = mem_din_q;
  assign hold_reset = hold_q;
  assign overflow   = ovf_q;
  assign dropped    = drop_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: transaction-level model plus directed and random stimulus.
// Build with ROM_LOADER_CHECKSUM_EN defined to also cover the checksum outputs.
module tb_rom_loader;

  typedef struct packed {
    logic [22:0] addr;
    logic [1:0]  bank;
    logic [7:0]  data;
  } ent_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_active = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        mem_ack = 1'b0;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_din;
  logic        hold_reset;
  logic        overflow;
  logic [7:0]  dropped;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic        csum_valid;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ack_mode = 0;   // 0: bench drives mem_ack directly, 1: random, 2: always 1

  always #5 clk_sys = ~clk_sys;

  rom_loader dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dl_active  (dl_active),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_bank   (mem_bank),
    .mem_din    (mem_din),
    .hold_reset (hold_reset),
    .overflow   (overflow),
    .dropped    (dropped)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .csum       (csum),
    .csum_valid (csum_valid)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Page map straight from the address rules
  function automatic ent_t map_ent(input logic [24:0] a, input logic [7:0] d);
    ent_t r;
    int unsigned p;
    logic [8:0] hi;
    p = 32'(a) / 16384;
    case (p % 4)
      0:       hi = 9'h000;
      1:       hi = 9'h100;
      2:       hi = 9'h107;
      default: hi = 9'h1FF;
    endcase
    r.addr = {hi, a[13:0]};
    r.bank = (p >= 4) ? 2'd1 : 2'd0;
    r.data = d;
    return r;
  endfunction

  // ---------------- reference model ----------------
  ent_t        mq[$];
  bit          pend_v = 0;
  ent_t        pend = '0;
  bit          e_we = 0;
  ent_t        e_out = '0;
  bit          e_hold = 0, e_ovf = 0, e_act = 0, e_cv = 0;
  int          e_tail = 0, e_drop = 0;
  logic [15:0] e_csum = '0;
  bit          started = 0;

  task automatic model_reset();
    mq.delete();
    pend_v = 0; e_we = 0; e_out = '0; e_hold = 0; e_ovf = 0; e_act = 0;
    e_cv = 0; e_tail = 0; e_drop = 0; e_csum = '0;
  endtask

  task automatic model_step();
    bit   pop_e, idle_e, rise_e;
    int   sz;
    ent_t popped;
    popped = '0;
    sz     = mq.size();
    pop_e  = e_we && mem_ack;
    idle_e = !dl_active && sz == 0 && !pend_v && !e_we;
    rise_e = dl_active && !e_act;
    if (e_we) begin
      if (mem_ack) begin
        popped = mq.pop_front();
        e_we = 0;
      end
    end else if (sz > 0) begin
      e_we  = 1;
      e_out = mq[0];
    end
    if (pend_v) begin
      if (sz < 4 || pop_e) mq.push_back(pend);
      else e_ovf = 1;
    end
    if (rise_e) e_csum = '0;
    if (pop_e) e_csum = e_csum + 16'(popped.data);
    if (rise_e) e_drop = 0;
    pend_v = 0;
    if (dl_active && dl_wr) begin
      if (32'(dl_addr) / 16384 <= 7) begin
        pend   = map_ent(dl_addr, dl_data);
        pend_v = 1;
      end else if (e_drop < 255) begin
        e_drop++;
      end
    end
    if (rise_e) begin
      e_hold = 1; e_tail = 0; e_cv = 0;
    end else if (e_hold && idle_e) begin
      e_tail++;
      if (e_tail == 16) begin
        e_hold = 0; e_tail = 0; e_cv = 1;
      end
    end else begin
      e_tail = 0;
    end
    e_act = dl_active;
  endtask

  initial forever begin
    @(posedge clk_sys or negedge reset_n);
    if (!reset_n) model_reset();
    else model_step();
    if (clk_sys) started = 1;
  end

  // Single compare process, every cycle
  initial forever begin
    @(negedge clk_sys);
    if (started) begin
      chk("mem_we",     32'(mem_we),     32'(e_we));
      chk("mem_addr",   32'(mem_addr),   32'(e_out.addr));
      chk("mem_bank",   32'(mem_bank),   32'(e_out.bank));
      chk("mem_din",    32'(mem_din),    32'(e_out.data));
      chk("hold_reset", 32'(hold_reset), 32'(e_hold));
      chk("overflow",   32'(overflow),   32'(e_ovf));
      chk("dropped",    32'(dropped),    32'(e_drop));
`ifdef ROM_LOADER_CHECKSUM_EN
      chk("csum",       32'(csum),       32'(e_csum));
      chk("csum_valid", 32'(csum_valid), 32'(e_cv));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk_sys);
    if (ack_mode == 1)      mem_ack = 1'($urandom_range(0, 1));
    else if (ack_mode == 2) mem_ack = 1'b1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic wait_we(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_we) begin ok = 1; break; end
      tick();
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic start_session();
    dl_active = 1'b1;
    tick();
    chk("hold_after_rise", 32'(hold_reset), 32'd1);
  endtask

  task automatic end_session(output int k);
    dl_active = 1'b0;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      k++;
      if (!hold_reset) break;
    end
  endtask

  initial begin
    int   k, hi, nw;
    ent_t exp_list[6];
    ent_t got_list[8];

    repeat (3) tick();
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_hold",   32'(hold_reset), 32'd0);
    reset_n = 1'b1;
    tick();

    // Single write with acknowledge in the third request cycle
    start_session();
    ack_mode = 0; mem_ack = 1'b0;
    strobe(25'h04123, 8'h5A);
    wait_we("wait_we_first");
    chk("first_addr", 32'(mem_addr), 32'h400123);
    chk("first_bank", 32'(mem_bank), 32'd0);
    chk("first_din",  32'(mem_din),  32'h5A);
    hi = 1;
    tick(); if (mem_we) hi++;
    tick(); if (mem_we) hi++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("we_after_ack", 32'(mem_we), 32'd0);
    chk("we_high_cycles", 32'(hi), 32'd3);
    end_session(k);
    chk("tail_len", 32'(k), 32'd16);

    // Bank 1 top page, out-of-range page, tail restart
    start_session();
    ack_mode = 2;
    strobe(25'h1C000, 8'hC3);
    wait_we("wait_we_bank1");
    chk("bank1_addr", 32'(mem_addr), 32'h7FC000);
    chk("bank1_bank", 32'(mem_bank), 32'd1);
    chk("bank1_din",  32'(mem_din),  32'hC3);
    repeat (4) tick();
    strobe(25'h20000, 8'h11);
    chk("dropped_one", 32'(dropped), 32'd1);
    nw = 0;
    repeat (10) begin tick(); if (mem_we) nw++; end
    chk("no_write_dropped", 32'(nw), 32'd0);
    dl_active = 1'b0;
    repeat (10) tick();
    chk("hold_mid_tail", 32'(hold_reset), 32'd1);
    dl_active = 1'b1;
    tick();
    chk("hold_after_rerise", 32'(hold_reset), 32'd1);
    end_session(k);
    chk("tail_after_rerise", 32'(k), 32'd16);

    // FIFO fill with acknowledge withheld
    start_session();
    ack_mode = 0; mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [24:0] a;
      a = {11'($urandom_range(0, 7)), 14'($urandom_range(0, 16383))};
      exp_list[i] = map_ent(a, 8'(8'h10 + i));
      strobe(a, 8'(8'h10 + i));
      tick(); tick();
      if (i == 3) chk("ovf_after_4", 32'(overflow), 32'd0);
      if (i == 4) chk("ovf_after_5", 32'(overflow), 32'd1);
    end
    ack_mode = 2;
    nw = 0;
    repeat (30) begin
      tick();
      if (mem_we && mem_ack) begin
        if (nw < 8) got_list[nw] = '{addr: mem_addr, bank: mem_bank, data: mem_din};
        nw++;
      end
    end
    chk("fill_write_count", 32'(nw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order_addr", 32'(got_list[i].addr), 32'(exp_list[i].addr));
      chk("fill_order_data", 32'(got_list[i].data), 32'(exp_list[i].data));
    end
    end_session(k);

    // Reset during an outstanding request
    start_session();
    ack_mode = 0; mem_ack = 1'b0;
    strobe(25'h0C001, 8'h77);
    wait_we("wait_we_reset");
    #2 reset_n = 1'b0;
    #1 chk("async_reset_we", 32'(mem_we), 32'd0);
    chk("async_reset_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    ack_mode = 2;
    nw = 0;
    repeat (10) begin tick(); if (mem_we) nw++; end
    chk("no_replay", 32'(nw), 32'd0);
    end_session(k);

    // Saturation of the dropped counter
    start_session();
    dl_wr = 1'b1; dl_addr = 25'h24000;
    repeat (260) tick();
    dl_wr = 1'b0;
    tick();
    chk("dropped_sat", 32'(dropped), 32'd255);
    end_session(k);

`ifdef ROM_LOADER_CHECKSUM_EN
    start_session();
    ack_mode = 2;
    for (int i = 0; i < 300; i++) begin
      strobe(25'(i), 8'hFF);
      tick(); tick();
    end
    end_session(k);
    chk("csum_value", 32'(csum), 32'h2AD4);
    chk("csum_valid_fall", 32'(csum_valid), 32'd1);
    start_session();
    chk("csum_valid_rise", 32'(csum_valid), 32'd0);
    end_session(k);
`endif

    // Randomised traffic
    ack_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      int unsigned p;
      p = ($urandom_range(0, 19) == 0) ? 32'd2047 : $urandom_range(0, 11);
      dl_wr   = 1'($urandom_range(0, 1));
      dl_addr = {11'(p), 14'($urandom_range(0, 16383))};
      dl_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) dl_active = ~dl_active;
      tick();
    end
    dl_wr = 1'b0; dl_active = 1'b0; ack_mode = 2;
    repeat (60) tick();
    chk("final_hold", 32'(hold_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
